// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of the single-port data memory.
// Three stages: accept (grant + legality check), memory access, registered response.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [2:0]            m0_funct3,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [2:0]            m1_funct3,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_err,
  output logic                  mem_wr_en,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  function automatic logic access_legal(input logic we, input logic [2:0] f3,
                                        input logic [1:0] a);
    logic f3_ok;
    logic align_ok;
    case (f3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !we;
      default:                f3_ok = 1'b0;
    endcase
    case (f3[1:0])
      2'b01:   align_ok = !a[0];
      2'b10:   align_ok = (a == 2'b00);
      default: align_ok = 1'b1;
    endcase
    return f3_ok && align_ok;
  endfunction

  logic                  last_owner_q, last_owner_d;
  logic                  vld_p1_q, vld_p1_d;
  logic                  owner_p1_q, owner_p1_d;
  logic                  we_p1_q, we_p1_d;
  logic                  err_p1_q, err_p1_d;
  logic [2:0]            funct3_p1_q, funct3_p1_d;
  logic [ADDR_WIDTH-1:0] addr_p1_q, addr_p1_d;
  logic [DATA_WIDTH-1:0] wdata_p1_q, wdata_p1_d;
  logic                  vld_p2_q, vld_p2_d;
  logic                  owner_p2_q, owner_p2_d;
  logic                  err_p2_q, err_p2_d;
  logic [DATA_WIDTH-1:0] rdata_p2_q, rdata_p2_d;

  // Stage A: grant and payload selection; last_owner breaks ties.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!reset) begin
      if (m0_req && (!m1_req || last_owner_q)) m0_gnt = 1'b1;
      else if (m1_req)                         m1_gnt = 1'b1;
    end
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (m0_gnt)      last_owner_d = 1'b0;
    else if (m1_gnt) last_owner_d = 1'b1;
    vld_p1_d    = m0_gnt | m1_gnt;
    owner_p1_d  = m1_gnt;
    we_p1_d     = m1_gnt ? m1_we     : m0_we;
    funct3_p1_d = m1_gnt ? m1_funct3 : m0_funct3;
    addr_p1_d   = m1_gnt ? m1_addr   : m0_addr;
    wdata_p1_d  = m1_gnt ? m1_wdata  : m0_wdata;
    err_p1_d    = !access_legal(we_p1_d, funct3_p1_d, addr_p1_d[1:0]);
  end

  // Stage M: an empty or rejected slot presents idle values so memory is never touched.
  always_comb begin
    mem_wr_en  = 1'b0;
    mem_funct3 = 3'b010;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (vld_p1_q && !err_p1_q) begin
      mem_wr_en  = we_p1_q;
      mem_funct3 = funct3_p1_q;
      mem_addr   = addr_p1_q;
      mem_wdata  = wdata_p1_q;
    end
  end

  always_comb begin
    vld_p2_d   = vld_p1_q;
    owner_p2_d = owner_p1_q;
    err_p2_d   = err_p1_q;
    rdata_p2_d = (vld_p1_q && !err_p1_q && !we_p1_q) ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner_q <= 1'b1;
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
    end else begin
      last_owner_q <= last_owner_d;
      vld_p1_q     <= vld_p1_d;
      vld_p2_q     <= vld_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    owner_p1_q  <= owner_p1_d;
    we_p1_q     <= we_p1_d;
    err_p1_q    <= err_p1_d;
    funct3_p1_q <= funct3_p1_d;
    addr_p1_q   <= addr_p1_d;
    wdata_p1_q  <= wdata_p1_d;
    owner_p2_q  <= owner_p2_d;
    err_p2_q    <= err_p2_d;
    rdata_p2_q  <= rdata_p2_d;
  end

  // Stage R: response steered to the owner recorded with the request.
  always_comb begin
    m0_rvalid = vld_p2_q && !owner_p2_q;
    m1_rvalid = vld_p2_q && owner_p2_q;
    m0_err    = m0_rvalid && err_p2_q;
    m1_err    = m1_rvalid && err_p2_q;
    m0_rdata  = m0_rvalid ? rdata_p2_q : '0;
    m1_rdata  = m1_rvalid ? rdata_p2_q : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural byte memory, queue of expected responses.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [2:0]  m0_funct3, m1_funct3;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_wr_en;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_funct3(m0_funct3), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_funct3(m1_funct3), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_err(m1_err),
    .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Little-endian byte memory; extension per funct3 happens here, as in the real memory.
  logic [7:0] tmem [0:255];
  always @(posedge clk) begin
    if (mem_wr_en) begin
      tmem[mem_addr[7:0]] <= mem_wdata[7:0];
      if (mem_funct3[1:0] != 2'b00) tmem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
      if (mem_funct3[1:0] == 2'b10) begin
        tmem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
        tmem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
      end
    end
  end

  always_comb begin
    logic [7:0]  a;
    logic [31:0] w;
    a = mem_addr[7:0];
    w = {tmem[a + 8'd3], tmem[a + 8'd2], tmem[a + 8'd1], tmem[a]};
    case (mem_funct3)
      3'b000:  mem_rdata = {{24{w[7]}}, w[7:0]};
      3'b100:  mem_rdata = {24'd0, w[7:0]};
      3'b001:  mem_rdata = {{16{w[15]}}, w[15:0]};
      3'b101:  mem_rdata = {16'd0, w[15:0]};
      default: mem_rdata = w;
    endcase
  end

  typedef struct {
    bit          owner;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
    int          due;
  } ent_t;

  ent_t        q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          exp_last = 1'b1;
  bit          pend_err [2];
  logic [31:0] pend_rd [2];

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, BAD = 3'b011;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_req(input bit p, input bit we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit eerr, input logic [31:0] erd);
    if (!p) begin
      m0_req = 1'b1; m0_we = we; m0_funct3 = f3; m0_addr = a; m0_wdata = wd;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_funct3 = f3; m1_addr = a; m1_wdata = wd;
    end
    pend_err[p] = eerr;
    pend_rd[p]  = erd;
  endtask

  // One clock cycle: check grant, M-stage and R-stage outputs, then advance.
  task automatic step();
    bit          g0, g1;
    ent_t        e;
    bit          rv0, rv1, er0, er1;
    logic [31:0] rd0, rd1;
    #1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!reset) begin
      if (m0_req && (!m1_req || exp_last)) g0 = 1'b1;
      else if (m1_req)                     g1 = 1'b1;
    end
    chk("m0_gnt", {31'd0, m0_gnt}, {31'd0, g0});
    chk("m1_gnt", {31'd0, m1_gnt}, {31'd0, g1});

    rv0 = 0; rv1 = 0; er0 = 0; er1 = 0; rd0 = '0; rd1 = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      if (!e.owner) begin rv0 = 1; er0 = e.err; rd0 = e.rdata; end
      else          begin rv1 = 1; er1 = e.err; rd1 = e.rdata; end
    end
    chk("m0_rvalid", {31'd0, m0_rvalid}, {31'd0, rv0});
    chk("m1_rvalid", {31'd0, m1_rvalid}, {31'd0, rv1});
    chk("m0_err", {31'd0, m0_err}, {31'd0, er0});
    chk("m1_err", {31'd0, m1_err}, {31'd0, er1});
    chk("m0_rdata", m0_rdata, rd0);
    chk("m1_rdata", m1_rdata, rd1);

    if (q.size() > 0 && q[0].due == cyc + 1 && !q[0].err) begin
      chk("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, q[0].we});
      chk("mem_funct3", {29'd0, mem_funct3}, {29'd0, q[0].f3});
      chk("mem_addr", mem_addr, q[0].addr);
      chk("mem_wdata", mem_wdata, q[0].wdata);
    end else begin
      chk("mem_wr_en_idle", {31'd0, mem_wr_en}, 32'd0);
      chk("mem_funct3_idle", {29'd0, mem_funct3}, 32'd2);
      chk("mem_addr_idle", mem_addr, 32'd0);
      chk("mem_wdata_idle", mem_wdata, 32'd0);
    end

    if (g0 || g1) begin
      e.owner = g1;
      e.we    = g1 ? m1_we : m0_we;
      e.f3    = g1 ? m1_funct3 : m0_funct3;
      e.addr  = g1 ? m1_addr : m0_addr;
      e.wdata = g1 ? m1_wdata : m0_wdata;
      e.err   = pend_err[g1];
      e.rdata = pend_rd[g1];
      e.due   = cyc + 2;
      q.push_back(e);
      exp_last = g1;
    end

    @(posedge clk);
    if (reset) begin
      q.delete();
      exp_last = 1'b1;
    end
    #1;
    cyc++;
    if (g0) m0_req = 1'b0;
    if (g1) m1_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    m0_req = 0; m0_we = 0; m0_funct3 = LW; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_funct3 = LW; m1_addr = '0; m1_wdata = '0;
    @(posedge clk); #1;
    step();
    reset = 1'b0;

    // m1 alone: three back-to-back stores, each to its own address
    set_req(1, 1, LW, 32'h40, 32'h1111_AAAA, 0, 32'h0); step();
    set_req(1, 1, LW, 32'h44, 32'h2222_BBBB, 0, 32'h0); step();
    set_req(1, 1, LW, 32'h48, 32'h3333_CCCC, 0, 32'h0); step();
    step(); step();

    // Continuous contention: grants m0, m1, m0, m1
    set_req(0, 0, LW, 32'h40, 32'h0, 0, 32'h1111_AAAA);
    set_req(1, 0, LW, 32'h44, 32'h0, 0, 32'h2222_BBBB);
    step();
    set_req(0, 0, LW, 32'h48, 32'h0, 0, 32'h3333_CCCC); step();
    set_req(1, 0, LW, 32'h40, 32'h0, 0, 32'h1111_AAAA); step();
    step();
    step(); step();

    // Store then load-back on m0
    set_req(0, 1, LW, 32'h10, 32'hDEAD_BEEF, 0, 32'h0); step();
    set_req(0, 0, LW, 32'h10, 32'h0, 0, 32'hDEAD_BEEF); step();
    step(); step();

    // Misaligned word store from m1 is rejected; the word at 0x10 is untouched
    set_req(1, 1, LW, 32'h12, 32'h1, 1, 32'h0); step();
    set_req(1, 0, LW, 32'h10, 32'h0, 0, 32'hDEAD_BEEF); step();
    step(); step();

    // Byte sign/zero extension, bad funct3, misaligned half, load-only funct3 on a store
    set_req(0, 1, LW, 32'h10, 32'h8000_0000, 0, 32'h0); step();
    set_req(0, 0, LB, 32'h13, 32'h0, 0, 32'hFFFF_FF80); step();
    set_req(0, 0, LBU, 32'h13, 32'h0, 0, 32'h0000_0080); step();
    set_req(0, 0, BAD, 32'h10, 32'h0, 1, 32'h0); step();
    set_req(0, 0, LH, 32'h11, 32'h0, 1, 32'h0); step();
    set_req(0, 1, LBU, 32'h10, 32'h55, 1, 32'h0); step();
    set_req(0, 0, LW, 32'h10, 32'h0, 0, 32'h8000_0000); step();
    step(); step();

    // Withdrawn request: no grant, no side effect
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h10; m1_wdata = 32'hFFFF_FFFF;
    reset = 1'b1; step(); m1_req = 1'b0; reset = 1'b0;
    step();

    // Reset the cycle after a grant drops the request; m0 wins first afterwards
    set_req(0, 0, LW, 32'h10, 32'h0, 0, 32'h8000_0000); step();
    reset = 1'b1;
    set_req(0, 0, LW, 32'h40, 32'h0, 0, 32'h1111_AAAA);
    set_req(1, 0, LW, 32'h44, 32'h0, 0, 32'h2222_BBBB);
    step();
    reset = 1'b0;
    step();
    step();
    step(); step();

    chk("scoreboard_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
